// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory between the CPU data port and a debug port.
// Debug bursts are bounded by DBG_MAX so the stalled CPU always makes progress.
module mem_arbiter #(
    parameter int DBG_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_dataW,
    input  logic        cpu_load,
    output logic [15:0] cpu_dataR,
    output logic        cpu_stall,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_address,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] dbg_rdata,

    output logic [15:0] mem_address,
    output logic [15:0] mem_dataW,
    output logic        mem_load,
    input  logic [15:0] mem_dataR
);

    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DBG = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DBG_MAX - 1);

    state_t     state;
    logic [7:0] cnt;

    // Leaving DBG always lands in CPU for at least one cycle, because the
    // only way back into DBG is a request sampled while in CPU.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CPU;
            cnt   <= 8'd0;
        end else if (state == ST_CPU) begin
            if (dbg_req) begin
                state <= ST_DBG;
                cnt   <= 8'd0;
            end
        end else begin
            if (!dbg_req || cnt == CNT_LAST) begin
                state <= ST_CPU;
                cnt   <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // A reset arriving mid-burst suppresses the in-flight transfer so the
    // interrupted request neither writes memory nor sees an ack.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        mem_address = cpu_address;
        mem_dataW   = cpu_dataW;
        mem_load    = cpu_load;
        cpu_stall   = 1'b0;
        dbg_ack     = 1'b0;
        if (state == ST_DBG) begin
            mem_address = dbg_address;
            mem_dataW   = dbg_wdata;
            mem_load    = dbg_req & dbg_we & ~reset;
            cpu_stall   = 1'b1;
            dbg_ack     = dbg_req & ~reset;
        end
    end

    assign cpu_dataR = mem_dataR;
    assign dbg_rdata = mem_dataR;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: a DBG_MAX=4 instance driven from a
// table against a behavioural memory, plus a DBG_MAX=1 alternation sequence.
module tb_mem_arbiter;

    typedef struct {
        logic        rst;
        logic [15:0] ca;
        logic [15:0] cw;
        logic        cl;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [15:0] dd;
        logic        x_stall;
        logic        x_ack;
        logic        x_load;
        logic [15:0] x_addr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DBG_MAX = 4 instance
    logic        reset;
    logic [15:0] cpu_address, cpu_dataW, cpu_dataR;
    logic        cpu_load, cpu_stall;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [15:0] dbg_address, dbg_wdata, dbg_rdata;
    logic [15:0] mem_address, mem_dataW, mem_dataR;
    logic        mem_load;

    logic [15:0] mem [0:65535];

    assign mem_dataR = mem[mem_address];
    always @(posedge clk) if (mem_load === 1'b1) mem[mem_address] <= mem_dataW;

    mem_arbiter #(.DBG_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_dataW(cpu_dataW), .cpu_load(cpu_load),
        .cpu_dataR(cpu_dataR), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_address(dbg_address),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_address(mem_address), .mem_dataW(mem_dataW), .mem_load(mem_load),
        .mem_dataR(mem_dataR)
    );

    // DBG_MAX = 1 instance
    logic        reset1;
    logic [15:0] cpu_dataR1, dbg_rdata1, mem_address1, mem_dataW1, mem_dataR1;
    logic        cpu_stall1, dbg_req1, dbg_ack1, mem_load1;

    assign mem_dataR1 = mem_address1 ^ 16'h0F0F;

    mem_arbiter #(.DBG_MAX(1)) dut1 (
        .clk(clk), .reset(reset1),
        .cpu_address(16'h0555), .cpu_dataW(16'h1234), .cpu_load(1'b0),
        .cpu_dataR(cpu_dataR1), .cpu_stall(cpu_stall1),
        .dbg_req(dbg_req1), .dbg_we(1'b1), .dbg_address(16'h0AAA),
        .dbg_wdata(16'h5678), .dbg_ack(dbg_ack1), .dbg_rdata(dbg_rdata1),
        .mem_address(mem_address1), .mem_dataW(mem_dataW1), .mem_load(mem_load1),
        .mem_dataR(mem_dataR1)
    );

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [15:0] ca, logic [15:0] cw, logic cl,
                                logic dr, logic dw, logic [15:0] da, logic [15:0] dd,
                                logic xs, logic xa, logic xl, logic [15:0] xaddr);
        vec_t v;
        v.rst = rst; v.ca = ca; v.cw = cw; v.cl = cl;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.x_stall = xs; v.x_ack = xa; v.x_load = xl; v.x_addr = xaddr;
        return v;
    endfunction

    function automatic logic [15:0] init_val(logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        reset       = v.rst;
        cpu_address = v.ca;
        cpu_dataW   = v.cw;
        cpu_load    = v.cl;
        dbg_req     = v.dr;
        dbg_we      = v.dw;
        dbg_address = v.da;
        dbg_wdata   = v.dd;
    endtask

    initial begin
        vec_t v;
        logic [15:0] exp_rd;
        logic [15:0] exp_a1;

        for (int a = 0; a < 65536; a++) mem[a] = init_val(16'(a));
        mem[16'h4000] = 16'h00A5;

        reset1 = 1'b1;
        dbg_req1 = 1'b0;
        drive(mk(1, 16'h0, 16'h0, 0, 1, 1, 16'h0, 16'h0, 0, 0, 0, 16'h0));

        // Idle CPU writes
        repeat (3) tbl.push_back(mk(0, 16'h0010, 16'hBEEF, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0010));
        // Held request, DBG_MAX=4: ack 0,1,1,1,1,0,1,1,1,1 with a pending CPU write
        tbl.push_back(mk(0, 16'h0020, 16'h1111, 1, 1, 1, 16'h0100, 16'hD000, 0, 0, 1, 16'h0020));
        tbl.push_back(mk(0, 16'h0020, 16'h1111, 1, 1, 1, 16'h0100, 16'hD000, 1, 1, 1, 16'h0100));
        tbl.push_back(mk(0, 16'h0020, 16'h1111, 1, 1, 1, 16'h0101, 16'hD001, 1, 1, 1, 16'h0101));
        tbl.push_back(mk(0, 16'h0020, 16'h1111, 1, 1, 1, 16'h0102, 16'hD002, 1, 1, 1, 16'h0102));
        tbl.push_back(mk(0, 16'h0020, 16'h1111, 1, 1, 1, 16'h0103, 16'hD003, 1, 1, 1, 16'h0103));
        tbl.push_back(mk(0, 16'h0020, 16'h1111, 1, 1, 1, 16'h0104, 16'hD004, 0, 0, 1, 16'h0020));
        tbl.push_back(mk(0, 16'h0020, 16'h1111, 1, 1, 1, 16'h0104, 16'hD004, 1, 1, 1, 16'h0104));
        tbl.push_back(mk(0, 16'h0020, 16'h1111, 1, 1, 1, 16'h0105, 16'hD005, 1, 1, 1, 16'h0105));
        tbl.push_back(mk(0, 16'h0020, 16'h1111, 1, 1, 1, 16'h0106, 16'hD006, 1, 1, 1, 16'h0106));
        tbl.push_back(mk(0, 16'h0020, 16'h1111, 1, 1, 1, 16'h0107, 16'hD007, 1, 1, 1, 16'h0107));
        tbl.push_back(mk(0, 16'h0030, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0030));
        // Debug read of 0x4000, then request dropped while in DBG
        tbl.push_back(mk(0, 16'h0030, 16'h0000, 0, 1, 0, 16'h4000, 16'h0000, 0, 0, 0, 16'h0030));
        tbl.push_back(mk(0, 16'h0030, 16'h0000, 0, 1, 0, 16'h4000, 16'h0000, 1, 1, 0, 16'h4000));
        tbl.push_back(mk(0, 16'h0030, 16'h0000, 0, 0, 0, 16'h4000, 16'h0000, 1, 0, 0, 16'h4000));
        // Two transfers, then request dropped: third DBG cycle has no side effect
        tbl.push_back(mk(0, 16'h0040, 16'h2222, 1, 1, 1, 16'h0200, 16'hE000, 0, 0, 1, 16'h0040));
        tbl.push_back(mk(0, 16'h0040, 16'h2222, 1, 1, 1, 16'h0200, 16'hE000, 1, 1, 1, 16'h0200));
        tbl.push_back(mk(0, 16'h0040, 16'h2222, 1, 1, 1, 16'h0201, 16'hE001, 1, 1, 1, 16'h0201));
        tbl.push_back(mk(0, 16'h0040, 16'h2222, 1, 0, 1, 16'h0202, 16'hE002, 1, 0, 0, 16'h0202));
        tbl.push_back(mk(0, 16'h0040, 16'h2222, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0040));
        // Reset on the second burst cycle aborts the transfer
        tbl.push_back(mk(0, 16'h0050, 16'h0000, 0, 1, 1, 16'h0300, 16'hF000, 0, 0, 0, 16'h0050));
        tbl.push_back(mk(0, 16'h0050, 16'h0000, 0, 1, 1, 16'h0300, 16'hF000, 1, 1, 1, 16'h0300));
        tbl.push_back(mk(1, 16'h0050, 16'h0000, 0, 1, 1, 16'h0301, 16'hF001, 1, 0, 0, 16'h0301));
        tbl.push_back(mk(0, 16'h0050, 16'h0000, 0, 1, 1, 16'h0301, 16'hF001, 0, 0, 0, 16'h0050));
        tbl.push_back(mk(0, 16'h0050, 16'h0000, 0, 0, 1, 16'h0301, 16'hF001, 1, 0, 0, 16'h0301));
        tbl.push_back(mk(0, 16'h0050, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0050));
        // Reset wins over a request sampled at the same edge
        tbl.push_back(mk(1, 16'h0050, 16'h0000, 0, 1, 1, 16'h0400, 16'h9999, 0, 0, 0, 16'h0050));
        tbl.push_back(mk(0, 16'h0050, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0050));

        @(posedge clk); #1;
        @(negedge clk);
        check("reset stall", 16'(cpu_stall), 16'h0);
        check("reset ack", 16'(dbg_ack), 16'h0);
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v);
            @(negedge clk);
            exp_rd = mem[v.x_addr];
            check($sformatf("v%0d stall", i), 16'(cpu_stall), 16'(v.x_stall));
            check($sformatf("v%0d ack", i), 16'(dbg_ack), 16'(v.x_ack));
            check($sformatf("v%0d load", i), 16'(mem_load), 16'(v.x_load));
            check($sformatf("v%0d addr", i), mem_address, v.x_addr);
            check($sformatf("v%0d cpu_dataR", i), cpu_dataR, exp_rd);
            check($sformatf("v%0d dbg_rdata", i), dbg_rdata, exp_rd);
            if (v.x_load)
                check($sformatf("v%0d dataW", i), mem_dataW, v.x_stall ? v.dd : v.cw);
            @(posedge clk); #1;
        end

        check("mem 0010", mem[16'h0010], 16'hBEEF);
        for (int k = 0; k < 8; k++)
            check($sformatf("mem 01%02h", k), mem[16'h0100 + 16'(k)], 16'hD000 + 16'(k));
        check("mem 4000", mem[16'h4000], 16'h00A5);
        check("mem 0040", mem[16'h0040], 16'h2222);
        check("mem 0200", mem[16'h0200], 16'hE000);
        check("mem 0201", mem[16'h0201], 16'hE001);
        check("mem 0202", mem[16'h0202], init_val(16'h0202));
        check("mem 0300", mem[16'h0300], 16'hF000);
        check("mem 0301", mem[16'h0301], init_val(16'h0301));
        check("mem 0400", mem[16'h0400], init_val(16'h0400));

        // DBG_MAX=1: strict alternation once the request is held
        reset1 = 1'b0;
        dbg_req1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_a1 = (i % 2 == 1) ? 16'h0AAA : 16'h0555;
            check($sformatf("alt%0d stall", i), 16'(cpu_stall1), 16'(i % 2));
            check($sformatf("alt%0d ack", i), 16'(dbg_ack1), 16'(i % 2));
            check($sformatf("alt%0d load", i), 16'(mem_load1), 16'(i % 2));
            check($sformatf("alt%0d addr", i), mem_address1, exp_a1);
            check($sformatf("alt%0d rdata", i), dbg_rdata1, exp_a1 ^ 16'h0F0F);
            @(posedge clk); #1;
        end
        dbg_req1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DBG_MAX, default 4, giving the maximum number of consecutive debug-owned cycles; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_address  input  16  CPU data address (addressM).
REQ-005 SHALL have port cpu_dataW  input  16  CPU write data (outM).
REQ-006 SHALL have port cpu_load  input  1  CPU write enable (loadM).
REQ-007 SHALL have port cpu_dataR  output  16  read data to the CPU (inM).
REQ-008 SHALL have port cpu_stall  output  1  CPU hold; while high the CPU does not advance pc or its registers.
REQ-009 SHALL have port dbg_req  input  1  debug port request.
REQ-010 SHALL have port dbg_we  input  1  debug write (1) or read (0).
REQ-011 SHALL have port dbg_address  input  16  debug address.
REQ-012 SHALL have port dbg_wdata  input  16  debug write data.
REQ-013 SHALL have port dbg_ack  output  1  debug transfer completes this cycle.
REQ-014 SHALL have port dbg_rdata  output  16  debug read data, valid when dbg_ack=1.
REQ-015 SHALL have ports mem_address (output, 16), mem_dataW (output, 16), mem_load (output, 1) and mem_dataR (input, 16), forming the shared Memory port; mem_dataR is combinational from mem_address.

Function
REQ-016 SHALL implement two states, CPU (CPU owns the Memory port) and DBG (debug owns it), with a burst counter cnt of 8 bits.
REQ-017 In CPU state: mem_address=cpu_address, mem_dataW=cpu_dataW, mem_load=cpu_load, cpu_stall=0, dbg_ack=0.
REQ-018 In DBG state: mem_address=dbg_address, mem_dataW=dbg_wdata, mem_load=dbg_we&dbg_req, cpu_stall=1, dbg_ack=dbg_req.
REQ-019 cpu_dataR and dbg_rdata SHALL both equal mem_dataR combinationally in every state; no added latency.
REQ-020 CPU->DBG transition: when dbg_req=1 is sampled at an edge in CPU state, the next state is DBG with cnt=0. The request is therefore granted one cycle after assertion.
REQ-021 In DBG, every cycle with dbg_req=1 is one transfer and increments cnt.
REQ-022 DBG->CPU transition occurs at the edge where dbg_req=0, or at the edge where a transfer completes with cnt=DBG_MAX-1.
REQ-023 After any DBG->CPU transition, the block SHALL remain in CPU state for at least one cycle, even if dbg_req is still 1; CPU progress is guaranteed.
REQ-024 DBG_MAX=1 SHALL alternate strictly: one debug cycle, then one CPU cycle.
REQ-025 dbg_req dropping in DBG state: that cycle mem_load=0 and dbg_ack=0, no memory side effect occurs, and the block returns to CPU at the next edge.
REQ-026 The debug requester SHALL hold dbg_we, dbg_address and dbg_wdata stable while dbg_req=1 and dbg_ack=0; the arbiter does not latch them.
REQ-027 cpu_load SHALL never reach mem_load while in DBG state; the stalled CPU's pending write is issued after it regains the port.
REQ-028 cnt SHALL never exceed DBG_MAX-1 and SHALL not wrap.

Reset
REQ-029 reset=1 at an edge SHALL force state=CPU and cnt=0, so that cpu_stall=0, dbg_ack=0 and the port is routed to the CPU from the next cycle.
REQ-030 Reset mid-burst SHALL abort the burst: no further debug writes occur and no ack is given for the interrupted request.
REQ-031 Reset SHALL take priority over dbg_req sampled at the same edge.

Verification
REQ-032 Idle, dbg_req=0, cpu_load=1, cpu_address=0x0010, cpu_dataW=0xBEEF -> mem_load=1, mem_address=0x0010 and cpu_stall=0 every cycle.
REQ-033 DBG_MAX=4, dbg_req held high for 10 cycles with writes to 0x0100.. -> ack pattern 0,1,1,1,1,0,1,1,1,1; cpu_stall is high on every ack cycle; mem_load is never driven by cpu_load while cpu_stall=1.
REQ-034 Debug read of 0x4000 where the memory returns 0x00A5 -> dbg_ack=1 and dbg_rdata=0x00A5 in the same cycle; mem_load=0.
REQ-035 dbg_req deasserted after 2 transfers (DBG_MAX=4) -> the third DBG cycle has ack=0 and mem_load=0; state=CPU the next cycle; cpu_stall returns to 0.
REQ-036 reset pulsed on the 2nd cycle of a burst -> the next cycle has state=CPU, dbg_ack=0 and cpu_stall=0; memory is unchanged at the interrupted address.
REQ-037 DBG_MAX=1 with dbg_req held high -> cpu_stall toggles 0,1,0,1,... after the first grant.
